// File: rtl/audio_sample_framer_pkg.sv
// rtl/audio_sample_framer_pkg.sv - shared constants, framed sample type and channel-status table
// Contents:
//   FRAMES_PER_BLOCK  frames per IEC 60958 channel-status block (192)
//   SAMPLE24_W        output sample width (24)
//   framed_sample_t   one FIFO entry: left/right samples plus per-frame metadata
//   cs_bits()         192-bit consumer channel-status block for a sample rate
package audio_framer_pkg;

    localparam int FRAMES_PER_BLOCK = 192;
    localparam int SAMPLE24_W       = 24;

    typedef struct packed {
        logic [SAMPLE24_W-1:0] left;
        logic [SAMPLE24_W-1:0] right;
        logic                  block_start;
        logic                  cs;
        logic [1:0]            parity;
    } framed_sample_t;

    // Bit n of the result is the channel-status bit sent in frame n.
    function automatic logic [FRAMES_PER_BLOCK-1:0] cs_bits(input int sample_rate);
        logic [FRAMES_PER_BLOCK-1:0] bits;
        bits    = '0;
        bits[2] = 1'b1;                 // copying permitted; consumer, linear PCM
        // Sampling-frequency code, bit 24 sent first
        case (sample_rate)
            44100: bits[27:24] = 4'b0000;
            32000: begin
                bits[24] = 1'b1;
                bits[25] = 1'b1;
            end
            default: bits[25] = 1'b1;   // 48 kHz
        endcase
        // Word length field: 24-bit samples
        bits[32] = 1'b1;
        bits[33] = 1'b1;
        bits[35] = 1'b1;
        return bits;
    endfunction

endpackage

// File: rtl/audio_sample_framer_if.sv
// rtl/audio_sample_framer_if.sv - framed sample stream toward the HDMI audio packet assembler
// Signals:
//   out_valid        head of the framer FIFO is valid
//   out_ready        consumer takes the head this cycle
//   out_left/right   24-bit left-justified samples
//   out_block_start  frame 0 of a 192-frame block
//   out_cs           channel-status bit (shared by both channels)
//   out_parity       even parity, [0] left, [1] right
interface audio_sample_framer_if;
    import audio_framer_pkg::*;

    logic                  out_valid;
    logic                  out_ready;
    logic [SAMPLE24_W-1:0] out_left;
    logic [SAMPLE24_W-1:0] out_right;
    logic                  out_block_start;
    logic                  out_cs;
    logic [1:0]            out_parity;

    modport master (
        output out_valid,
        output out_left,
        output out_right,
        output out_block_start,
        output out_cs,
        output out_parity,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_left,
        input  out_right,
        input  out_block_start,
        input  out_cs,
        input  out_parity,
        output out_ready
    );

endinterface

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - show-ahead FIFO of framed_sample_t with registered storage
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (clears storage, pointers, count)
//   i_push        write i_push_data at the tail
//   i_push_data   entry to store
//   i_pop         drop the head (caller only pops when non-empty)
//   o_head        current head entry, valid whenever !o_empty
//   o_empty       no entries
//   o_full        DEPTH entries held
module audio_sample_fifo
    import audio_framer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_push,
    input  framed_sample_t i_push_data,
    input  logic           i_pop,
    output framed_sample_t o_head,
    output logic           o_empty,
    output logic           o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    framed_sample_t r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW + 1)'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr];

    // Storage is reset so the outputs read as zero straight out of reset.
    // When full, a same-cycle pop and push hit the same slot: the head is
    // read combinationally before the edge overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_framer.sv
// rtl/audio_sample_framer.sv - left-justifies stereo PCM, adds IEC 60958 frame metadata, buffers for HDMI
// Optional statistics enabled by defining AUDIO_FRAMER_STATS_EN.
// Ports:
//   clk_audio, reset_n         sample clock, asynchronous active-low reset
//   sample_valid               left/right pair present this cycle
//   level_left, level_right    signed BIT_WIDTH samples
//   out_if (master)            framed sample stream with valid/ready
//   overflow                   one-cycle pulse after a sample is dropped
//   drop_count   (stats only)  saturating count of dropped samples
//   max_level    (stats only)  peak |level_left| of accepted samples, saturating
//   stats_clear  (stats only)  synchronous zero of both statistics
module audio_sample_framer
    import audio_framer_pkg::*;
#(
    parameter int BIT_WIDTH   = 16,
    parameter int SAMPLE_RATE = 48000,
    parameter int DEPTH       = 4
) (
    input  logic                        clk_audio,
    input  logic                        reset_n,
    input  logic                        sample_valid,
    input  logic signed [BIT_WIDTH-1:0] level_left,
    input  logic signed [BIT_WIDTH-1:0] level_right,
    audio_sample_framer_if.master       out_if,
    output logic                        overflow
`ifdef AUDIO_FRAMER_STATS_EN
    ,
    output logic [15:0]                 drop_count,
    output logic [BIT_WIDTH-1:0]        max_level,
    input  logic                        stats_clear
`endif
);

    localparam logic [FRAMES_PER_BLOCK-1:0] CS_BITS = cs_bits(SAMPLE_RATE);
    localparam logic V_BIT = 1'b0;
    localparam logic U_BIT = 1'b0;

    logic [7:0]            r_frame_idx;
    logic                  r_overflow;
    logic [SAMPLE24_W-1:0] w_left24;
    logic [SAMPLE24_W-1:0] w_right24;
    logic                  w_cs;
    framed_sample_t        w_push_data;
    framed_sample_t        w_head;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign w_pop  = !w_empty && out_if.out_ready;
    assign w_push = sample_valid && (!w_full || w_pop);
    assign w_drop = sample_valid && w_full && !w_pop;

    // Sign-extend to 24 bits then shift: equals {level, zeros} without a
    // zero-width replication when BIT_WIDTH is 24.
    assign w_left24  = SAMPLE24_W'(level_left)  << (SAMPLE24_W - BIT_WIDTH);
    assign w_right24 = SAMPLE24_W'(level_right) << (SAMPLE24_W - BIT_WIDTH);
    assign w_cs      = CS_BITS[r_frame_idx];

    always_comb begin
        w_push_data             = '0;
        w_push_data.left        = w_left24;
        w_push_data.right       = w_right24;
        w_push_data.block_start = (r_frame_idx == 8'd0);
        w_push_data.cs          = w_cs;
        w_push_data.parity[0]   = ^{w_left24,  V_BIT, U_BIT, w_cs};
        w_push_data.parity[1]   = ^{w_right24, V_BIT, U_BIT, w_cs};
    end

    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_idx <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_push) begin
                r_frame_idx <= (r_frame_idx == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : r_frame_idx + 8'd1;
            end
        end
    end

    audio_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk_audio),
        .rst_n       (reset_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    assign out_if.out_valid       = !w_empty;
    assign out_if.out_left        = w_head.left;
    assign out_if.out_right       = w_head.right;
    assign out_if.out_block_start = w_head.block_start;
    assign out_if.out_cs          = w_head.cs;
    assign out_if.out_parity      = w_head.parity;
    assign overflow               = r_overflow;

`ifdef AUDIO_FRAMER_STATS_EN
    localparam logic [BIT_WIDTH-1:0] MAX_MAG = {1'b0, {(BIT_WIDTH - 1){1'b1}}};

    logic [15:0]          r_drop_count;
    logic [BIT_WIDTH-1:0] r_max_level;
    logic [BIT_WIDTH:0]   w_mag;
    logic [BIT_WIDTH-1:0] w_mag_sat;

    // One extra bit so the most negative input has a representable magnitude
    // before it is clipped.
    always_comb begin
        w_mag = '0;
        if (level_left[BIT_WIDTH-1]) begin
            w_mag = (BIT_WIDTH + 1)'(0) - {1'b1, level_left};
        end else begin
            w_mag = {1'b0, level_left};
        end
        w_mag_sat = (w_mag > {1'b0, MAX_MAG}) ? MAX_MAG : w_mag[BIT_WIDTH-1:0];
    end

    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
            r_max_level  <= '0;
        end else if (stats_clear) begin
            r_drop_count <= '0;
            r_max_level  <= '0;
        end else begin
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
            if (w_push && (w_mag_sat > r_max_level)) begin
                r_max_level <= w_mag_sat;
            end
        end
    end

    assign drop_count = r_drop_count;
    assign max_level  = r_max_level;
`endif

endmodule
